// File: rtl/sort_engine_p.sv
// rtl/sort_engine_p.sv - in-place bubble-sort engine driving a synchronous-read single-port RAM
module sort_engine_p #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int SIGNED_CMP = 0,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int SWAP_W     = $clog2(DEPTH*(DEPTH-1)/2+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              descending,
    input  logic              early_exit_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [SWAP_W-1:0] swap_count,
    output logic [ADDR_W-1:0] pass_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_LDA, S_CAPA, S_RDB, S_CMP, S_WRJ, S_WRJ1, S_STEP, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [SWAP_W-1:0] S_ONE  = SWAP_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_j;
    logic [ADDR_W-1:0]   r_limit;
    logic [DATA_W-1:0]   r_a;
    logic                r_swapped;
    logic                r_desc;
    logic                r_ee;

    logic [ADDR_W-1:0]   w_j1;
    logic                w_a_gt_b;
    logic                w_b_gt_a;
    logic                w_swap;

    assign w_j1 = r_j + A_ONE;

    // B is compared straight off the RAM read port in CMP; equal values never swap.
    always_comb begin
        w_a_gt_b = 1'b0;
        w_b_gt_a = 1'b0;
        if (SIGNED_CMP != 0) begin
            w_a_gt_b = $signed(r_a) > $signed(mem_rdata);
            w_b_gt_a = $signed(mem_rdata) > $signed(r_a);
        end else begin
            w_a_gt_b = r_a > mem_rdata;
            w_b_gt_a = mem_rdata > r_a;
        end
        w_swap = r_desc ? w_b_gt_a : w_a_gt_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_j        <= '0;
            r_limit    <= '0;
            r_a        <= '0;
            r_swapped  <= 1'b0;
            r_desc     <= 1'b0;
            r_ee       <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            swap_count <= '0;
            pass_count <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_desc     <= descending;
                        r_ee       <= early_exit_en;
                        r_j        <= '0;
                        r_limit    <= A_LAST;
                        r_swapped  <= 1'b0;
                        swap_count <= '0;
                        pass_count <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        mem_rd_en  <= 1'b1;
                        mem_addr   <= '0;
                        r_state    <= S_LDA;
                    end
                end
                S_LDA: r_state <= S_CAPA;
                S_CAPA: begin
                    r_a       <= mem_rdata;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= w_j1;
                    r_state   <= S_RDB;
                end
                S_RDB: r_state <= S_CMP;
                S_CMP: begin
                    if (w_swap) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= r_j;
                        mem_wdata <= mem_rdata;
                        r_state   <= S_WRJ;
                    end else begin
                        r_a     <= mem_rdata;
                        r_state <= S_STEP;
                    end
                end
                S_WRJ: begin
                    r_swapped  <= 1'b1;
                    swap_count <= swap_count + S_ONE;
                    mem_wr_en  <= 1'b1;
                    mem_addr   <= w_j1;
                    mem_wdata  <= r_a;
                    r_state    <= S_WRJ1;
                end
                S_WRJ1: r_state <= S_STEP;
                S_STEP: begin
                    if (w_j1 < r_limit) begin
                        r_j       <= w_j1;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= w_j1 + A_ONE;
                        r_state   <= S_RDB;
                    end else begin
                        pass_count <= pass_count + A_ONE;
                        if (r_limit == A_ONE || (r_ee && !r_swapped)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_limit   <= r_limit - A_ONE;
                            r_j       <= '0;
                            r_swapped <= 1'b0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                            r_state   <= S_LDA;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_engine_p.sv
// tb/tb_sort_engine_p.sv - randomized self-checking bench for sort_engine_p against a bubble-sort model
module tb_sort_engine_p;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: DEPTH=4, signed compare
    logic       a_start, a_desc, a_ee, a_rd, a_wr, a_busy, a_done;
    logic [1:0] a_addr, a_passes;
    logic [2:0] a_swaps;
    logic [7:0] a_rdata, a_wdata;
    logic       a_ld;
    logic [1:0] a_ld_addr;
    logic [7:0] a_ld_data;
    logic [7:0] mem_a [0:3];

    // Instance B: DEPTH=16, unsigned compare
    logic       b_start, b_desc, b_ee, b_rd, b_wr, b_busy, b_done;
    logic [3:0] b_addr, b_passes;
    logic [6:0] b_swaps;
    logic [7:0] b_rdata, b_wdata;
    logic       b_ld;
    logic [3:0] b_ld_addr;
    logic [7:0] b_ld_data;
    logic [7:0] mem_b [0:15];

    int b_wr_total = 0;
    int overlap    = 0;

    sort_engine_p #(.DATA_W(8), .DEPTH(4), .SIGNED_CMP(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .descending(a_desc),
        .early_exit_en(a_ee), .mem_addr(a_addr), .mem_rd_en(a_rd),
        .mem_rdata(a_rdata), .mem_wr_en(a_wr), .mem_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .swap_count(a_swaps), .pass_count(a_passes)
    );

    sort_engine_p #(.DATA_W(8), .DEPTH(16), .SIGNED_CMP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .descending(b_desc),
        .early_exit_en(b_ee), .mem_addr(b_addr), .mem_rd_en(b_rd),
        .mem_rdata(b_rdata), .mem_wr_en(b_wr), .mem_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .swap_count(b_swaps), .pass_count(b_passes)
    );

    always @(posedge clk) begin
        if (a_wr) mem_a[a_addr] <= a_wdata;
        else if (a_ld) mem_a[a_ld_addr] <= a_ld_data;
        if (a_rd) a_rdata <= mem_a[a_addr];
        if (b_wr) mem_b[b_addr] <= b_wdata;
        else if (b_ld) mem_b[b_ld_addr] <= b_ld_data;
        if (b_rd) b_rdata <= mem_b[b_addr];
        if (b_wr) b_wr_total++;
        if ((a_rd && a_wr) || (b_rd && b_wr)) overlap++;
    end

    function automatic void bubble(input int vin[$], input bit sgn, input bit desc, input bit ee,
                                   output int vout[$], output int swaps, output int passes,
                                   output int cycles);
        int v[$];
        int lim, s, t, x, y;
        bit fin;
        logic [7:0] bx, by;
        v = vin; lim = v.size() - 1; swaps = 0; passes = 0; cycles = 0; fin = 0;
        while (!fin) begin
            s = 0;
            for (int j = 0; j < lim; j++) begin
                bx = 8'(v[j]); by = 8'(v[j+1]);
                x = sgn ? int'($signed(bx)) : int'(bx);
                y = sgn ? int'($signed(by)) : int'(by);
                if (desc ? (x < y) : (x > y)) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t; s++;
                end
            end
            passes++; swaps += s; cycles += 2 + 3*lim + 2*s;
            if (lim == 1 || (ee && s == 0)) fin = 1;
            else lim--;
        end
        vout = v;
    endfunction

    task automatic load_a(input int v[$]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); a_ld = 1'b1; a_ld_addr = 2'(i); a_ld_data = 8'(v[i]);
        end
        @(negedge clk); a_ld = 1'b0;
    endtask

    task automatic load_b(input int v[$]);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); b_ld = 1'b1; b_ld_addr = 4'(i); b_ld_data = 8'(v[i]);
        end
        @(negedge clk); b_ld = 1'b0;
    endtask

    // Runs a sort on A; at busy cycle `mid` a stray start with flipped order is pulsed.
    task automatic run_a(input bit desc, input bit ee, input int mid, output int cyc);
        @(negedge clk); a_desc = desc; a_ee = ee; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; cyc = 0;
        while (a_busy === 1'b1 && cyc < 5000) begin
            cyc++;
            a_start = (cyc == mid);
            a_desc  = (cyc == mid) ? ~desc : desc;
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    task automatic run_b(input bit desc, input bit ee, output int cyc);
        @(negedge clk); b_desc = desc; b_ee = ee; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; cyc = 0;
        while (b_busy === 1'b1 && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({b_busy, b_done, b_rd, b_wr} !== 4'b0) begin errors++;
            $display("FAIL reset_b_ctl: got %b want 0000", {b_busy, b_done, b_rd, b_wr}); end
        checks++; if ({b_addr, b_wdata} !== 12'h0) begin errors++;
            $display("FAIL reset_b_mem: addr=%0h wdata=%0h want 0", b_addr, b_wdata); end
        checks++; if ({b_swaps, b_passes} !== 11'h0) begin errors++;
            $display("FAIL reset_b_cnt: swaps=%0d passes=%0d want 0", b_swaps, b_passes); end
        checks++; if ({a_busy, a_done, a_rd, a_wr} !== 4'b0) begin errors++;
            $display("FAIL reset_a_ctl: got %b want 0000", {a_busy, a_done, a_rd, a_wr}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reverse4;
        int cyc;
        int exp[4] = '{1, 2, 3, 4};
        load_a('{4, 3, 2, 1});
        run_a(1'b0, 1'b1, 0, cyc);
        for (int i = 0; i < 4; i++) begin
            checks++; if (int'(mem_a[i]) !== exp[i]) begin errors++;
                $display("FAIL rev4_ram[%0d]: got %0d want %0d", i, mem_a[i], exp[i]); end
        end
        checks++; if (int'(a_swaps) !== 6 || int'(a_passes) !== 3) begin errors++;
            $display("FAIL rev4_counts: swaps=%0d passes=%0d want 6/3", a_swaps, a_passes); end
        checks++; if (cyc !== 36) begin errors++;
            $display("FAIL rev4_busy_cycles: got %0d want 36", cyc); end
        checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin errors++;
            $display("FAIL rev4_done: done=%b busy=%b want 1/0", a_done, a_busy); end
    endtask

    task automatic test_sorted16;
        int q[$];
        int cyc, w0;
        for (int i = 0; i < 16; i++) q.push_back(i);
        load_b(q);
        w0 = b_wr_total;
        run_b(1'b0, 1'b1, cyc);
        checks++; if (b_wr_total - w0 !== 0) begin errors++;
            $display("FAIL sorted_ee_writes: got %0d want 0", b_wr_total - w0); end
        checks++; if (int'(b_swaps) !== 0 || int'(b_passes) !== 1 || cyc !== 47) begin errors++;
            $display("FAIL sorted_ee: swaps=%0d passes=%0d cycles=%0d want 0/1/47", b_swaps, b_passes, cyc); end
        run_b(1'b0, 1'b0, cyc);
        checks++; if (int'(b_swaps) !== 0 || int'(b_passes) !== 15 || cyc !== 390) begin errors++;
            $display("FAIL sorted_full: swaps=%0d passes=%0d cycles=%0d want 0/15/390", b_swaps, b_passes, cyc); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (int'(mem_b[i]) !== i) begin errors++;
                $display("FAIL sorted_ram[%0d]: got %0d want %0d", i, mem_b[i], i); end
        end
    endtask

    task automatic test_signed_desc;
        int cyc;
        int exp[4] = '{'h7F, 'h00, 'hFF, 'h80};
        load_a('{'h80, 'h7F, 'h00, 'hFF});
        run_a(1'b1, 1'b1, 0, cyc);
        for (int i = 0; i < 4; i++) begin
            checks++; if (int'(mem_a[i]) !== exp[i]) begin errors++;
                $display("FAIL sdesc_ram[%0d]: got %0h want %0h", i, mem_a[i], exp[i]); end
        end
        checks++; if (int'(a_swaps) !== 3 || int'(a_passes) !== 2 || cyc !== 25) begin errors++;
            $display("FAIL sdesc_counts: swaps=%0d passes=%0d cycles=%0d want 3/2/25", a_swaps, a_passes, cyc); end
    endtask

    task automatic test_ties_midstart;
        int cyc;
        int exp[4] = '{1, 1, 2, 2};
        load_a('{2, 2, 1, 1});
        run_a(1'b0, 1'b1, 10, cyc);
        for (int i = 0; i < 4; i++) begin
            checks++; if (int'(mem_a[i]) !== exp[i]) begin errors++;
                $display("FAIL ties_ram[%0d]: got %0d want %0d", i, mem_a[i], exp[i]); end
        end
        checks++; if (int'(a_swaps) !== 4 || int'(a_passes) !== 3 || cyc !== 32) begin errors++;
            $display("FAIL ties_counts: swaps=%0d passes=%0d cycles=%0d want 4/3/32", a_swaps, a_passes, cyc); end
    endtask

    task automatic test_random_a;
        int q[$], r[$];
        int sw, ps, cy, cyc;
        bit desc, ee;
        for (int it = 0; it < 6; it++) begin
            q.delete();
            for (int i = 0; i < 4; i++) q.push_back(int'($urandom_range(0, 255)));
            desc = 1'($urandom); ee = 1'($urandom);
            load_a(q);
            bubble(q, 1'b1, desc, ee, r, sw, ps, cy);
            run_a(desc, ee, 0, cyc);
            for (int i = 0; i < 4; i++) begin
                checks++; if (int'(mem_a[i]) !== r[i]) begin errors++;
                    $display("FAIL rand_a%0d_ram[%0d]: got %0h want %0h", it, i, mem_a[i], r[i]); end
            end
            checks++; if (int'(a_swaps) !== sw || int'(a_passes) !== ps || cyc !== cy) begin errors++;
                $display("FAIL rand_a%0d_counts: swaps=%0d passes=%0d cycles=%0d want %0d/%0d/%0d",
                         it, a_swaps, a_passes, cyc, sw, ps, cy); end
        end
    endtask

    task automatic test_random_b;
        int q[$], r[$];
        int sw, ps, cy, cyc;
        bit desc, ee;
        for (int it = 0; it < 8; it++) begin
            q.delete();
            for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(0, (it % 2) ? 3 : 255)));
            desc = 1'($urandom); ee = 1'($urandom);
            load_b(q);
            bubble(q, 1'b0, desc, ee, r, sw, ps, cy);
            run_b(desc, ee, cyc);
            for (int i = 0; i < 16; i++) begin
                checks++; if (int'(mem_b[i]) !== r[i]) begin errors++;
                    $display("FAIL rand_b%0d_ram[%0d]: got %0d want %0d", it, i, mem_b[i], r[i]); end
            end
            checks++; if (int'(b_swaps) !== sw || int'(b_passes) !== ps || cyc !== cy) begin errors++;
                $display("FAIL rand_b%0d_counts: swaps=%0d passes=%0d cycles=%0d want %0d/%0d/%0d",
                         it, b_swaps, b_passes, cyc, sw, ps, cy); end
            checks++; if (b_done !== 1'b1) begin errors++;
                $display("FAIL rand_b%0d_done: got %b want 1", it, b_done); end
        end
    endtask

    task automatic test_reset_midwrite;
        int q[$], r[$];
        int sw, ps, cy, cyc, w;
        for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(0, 255)));
        q[0] = 255;
        load_b(q);
        @(negedge clk); b_desc = 1'b0; b_ee = 1'b1; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        w = 0;
        while (b_wr !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        checks++; if (w >= 2000) begin errors++;
            $display("FAIL rst_wait_wrj: no write strobe within %0d cycles", w); end
        rst_n = 1'b0;
        #1;
        checks++; if ({b_busy, b_done, b_rd, b_wr} !== 4'b0) begin errors++;
            $display("FAIL rst_mid_immediate: busy/done/rd/wr=%b want 0000", {b_busy, b_done, b_rd, b_wr}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if ({b_busy, b_done, b_rd, b_wr} !== 4'b0) begin errors++;
                $display("FAIL rst_mid_after%0d: busy/done/rd/wr=%b want 0000", k, {b_busy, b_done, b_rd, b_wr}); end
        end
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(int'(mem_b[i]));
        bubble(q, 1'b0, 1'b0, 1'b1, r, sw, ps, cy);
        run_b(1'b0, 1'b1, cyc);
        for (int i = 0; i < 16; i++) begin
            checks++; if (int'(mem_b[i]) !== r[i]) begin errors++;
                $display("FAIL rst_resort_ram[%0d]: got %0d want %0d", i, mem_b[i], r[i]); end
        end
        checks++; if (int'(b_swaps) !== sw || int'(b_passes) !== ps || cyc !== cy) begin errors++;
            $display("FAIL rst_resort_counts: swaps=%0d passes=%0d cycles=%0d want %0d/%0d/%0d",
                     b_swaps, b_passes, cyc, sw, ps, cy); end
    endtask

    task automatic test_strobes;
        checks++; if (overlap !== 0) begin errors++;
            $display("FAIL strobe_overlap: rd and wr together %0d times, want 0", overlap); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 0; a_desc = 0; a_ee = 0; a_ld = 0; a_ld_addr = 0; a_ld_data = 0;
        b_start = 0; b_desc = 0; b_ee = 0; b_ld = 0; b_ld_addr = 0; b_ld_data = 0;
        test_reset;
        test_reverse4;
        test_sorted16;
        test_signed_desc;
        test_ties_midstart;
        test_random_a;
        test_random_b;
        test_reset_midwrite;
        test_strobes;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
